// File: rtl/grid_write_arbiter.sv
// grid_write_arbiter
// Shares the single VGA grid-memory write port between the player-paint and
// wall-paint requesters (round-robin) and sequences a full-grid clear sweep.
//
// Ports:
//   clock, resetn            clock, asynchronous active-low reset
//   play_req/addr/data       player-paint request, held until play_ack
//   play_ack                 one-cycle pulse, player write on the port this cycle
//   wall_req/addr/data       wall-paint request, held until wall_ack
//   wall_ack                 one-cycle pulse, wall write on the port this cycle
//   clear_start              one-cycle pulse that starts a clear sweep
//   clear_busy               high during every sweep write cycle
//   wren_gridData            grid write enable
//   wraddress_gridData       grid write address
//   data_gridData            grid write data
module grid_write_arbiter #(
    parameter int unsigned       ADDR_W     = 12,
    parameter int unsigned       DATA_W     = 4,
    parameter int unsigned       GRID_CELLS = 4096,
    parameter logic [DATA_W-1:0] CLEAR_VAL  = '0
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              play_req,
    input  logic [ADDR_W-1:0] play_addr,
    input  logic [DATA_W-1:0] play_data,
    output logic              play_ack,
    input  logic              wall_req,
    input  logic [ADDR_W-1:0] wall_addr,
    input  logic [DATA_W-1:0] wall_data,
    output logic              wall_ack,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              wren_gridData,
    output logic [ADDR_W-1:0] wraddress_gridData,
    output logic [DATA_W-1:0] data_gridData
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    localparam logic GRANT_PLAY = 1'b0;
    localparam logic GRANT_WALL = 1'b1;

    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(GRID_CELLS - 1);

    logic [0:0]        state_q;
    logic [0:0]        state_d;
    logic [ADDR_W-1:0] count_q;
    logic [ADDR_W-1:0] count_d;
    logic              last_grant_q;
    logic              last_grant_d;

    logic              wren_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] data_d;
    logic              play_ack_d;
    logic              wall_ack_d;
    logic              busy_d;

    logic              play_elig;
    logic              wall_elig;
    logic              sweep;

    // A requester still seeing its ack is not eligible, so it cannot be granted twice.
    assign play_elig = play_req && !play_ack;
    assign wall_elig = wall_req && !wall_ack;

    // Next-state and next-output decode.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        last_grant_d = last_grant_q;
        wren_d       = 1'b0;
        addr_d       = wraddress_gridData;
        data_d       = data_gridData;
        play_ack_d   = 1'b0;
        wall_ack_d   = 1'b0;
        busy_d       = 1'b0;
        sweep        = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                sweep = 1'b1;
            end
            default: begin
                if (clear_start) begin
                    sweep = 1'b1;
                end else if (play_elig && (!wall_elig || last_grant_q == GRANT_WALL)) begin
                    wren_d       = 1'b1;
                    addr_d       = play_addr;
                    data_d       = play_data;
                    play_ack_d   = 1'b1;
                    last_grant_d = GRANT_PLAY;
                end else if (wall_elig) begin
                    wren_d       = 1'b1;
                    addr_d       = wall_addr;
                    data_d       = wall_data;
                    wall_ack_d   = 1'b1;
                    last_grant_d = GRANT_WALL;
                end
            end
        endcase

        // The sweep write for count_q is registered here and appears next cycle;
        // after registering the last cell the FSM is back in IDLE, so arbitration
        // runs while that last write is on the port.
        if (sweep) begin
            wren_d = 1'b1;
            addr_d = count_q;
            data_d = CLEAR_VAL;
            busy_d = 1'b1;
            if (count_q == LAST_CELL) begin
                count_d = '0;
                state_d = ST_IDLE;
            end else begin
                count_d = count_q + ADDR_W'(1);
                state_d = ST_CLEAR;
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q            <= ST_IDLE;
            count_q            <= '0;
            last_grant_q       <= GRANT_WALL;
            wren_gridData      <= 1'b0;
            wraddress_gridData <= '0;
            data_gridData      <= '0;
            play_ack           <= 1'b0;
            wall_ack           <= 1'b0;
            clear_busy         <= 1'b0;
        end else begin
            state_q            <= state_d;
            count_q            <= count_d;
            last_grant_q       <= last_grant_d;
            wren_gridData      <= wren_d;
            wraddress_gridData <= addr_d;
            data_gridData      <= data_d;
            play_ack           <= play_ack_d;
            wall_ack           <= wall_ack_d;
            clear_busy         <= busy_d;
        end
    end

endmodule

// File: tb/tb_grid_write_arbiter.sv
// Self-checking bench for grid_write_arbiter (GRID_CELLS reduced to 16).
// Expected port words are queued one cycle ahead when stimulus is driven and
// popped by a negedge monitor in the cycle they are due.
module tb_grid_write_arbiter;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned CELLS  = 16;

    logic              clock = 1'b0;
    logic              resetn;
    logic              play_req;
    logic [ADDR_W-1:0] play_addr;
    logic [DATA_W-1:0] play_data;
    logic              play_ack;
    logic              wall_req;
    logic [ADDR_W-1:0] wall_addr;
    logic [DATA_W-1:0] wall_data;
    logic              wall_ack;
    logic              clear_start;
    logic              clear_busy;
    logic              wren_gridData;
    logic [ADDR_W-1:0] wraddress_gridData;
    logic [DATA_W-1:0] data_gridData;

    grid_write_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .GRID_CELLS (CELLS),
        .CLEAR_VAL  (4'h0)
    ) dut (
        .clock              (clock),
        .resetn             (resetn),
        .play_req           (play_req),
        .play_addr          (play_addr),
        .play_data          (play_data),
        .play_ack           (play_ack),
        .wall_req           (wall_req),
        .wall_addr          (wall_addr),
        .wall_data          (wall_data),
        .wall_ack           (wall_ack),
        .clear_start        (clear_start),
        .clear_busy         (clear_busy),
        .wren_gridData      (wren_gridData),
        .wraddress_gridData (wraddress_gridData),
        .data_gridData      (data_gridData)
    );

    always #5 clock = ~clock;

    typedef struct {
        int unsigned due;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc    = 0;
    int unsigned n_cmp  = 0;
    int unsigned n_bad  = 0;
    logic [ADDR_W-1:0] last_addr = '0;
    logic [DATA_W-1:0] last_data = '0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        if (cyc > 3000) begin
            $display("FAIL watchdog: got cycle %0d want < 3000", cyc);
            $fatal(1, "watchdog expired");
        end
    end

    // Port word: {pad, wren, busy, play_ack, wall_ack, addr, data}
    function automatic logic [31:0] obs_word();
        return {12'h0, wren_gridData, clear_busy, play_ack, wall_ack,
                wraddress_gridData, data_gridData};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic push(input string tag, input logic w, input logic b, input logic pa,
                        input logic wa, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        exp_t e;
        e.due = cyc + 1;
        e.val = {12'h0, w, b, pa, wa, a, d};
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic exp_none(input string tag);
        push(tag, 1'b0, 1'b0, 1'b0, 1'b0, last_addr, last_data);
    endtask

    task automatic exp_play(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        push(tag, 1'b1, 1'b0, 1'b1, 1'b0, a, d);
        last_addr = a;
        last_data = d;
    endtask

    task automatic exp_wall(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        push(tag, 1'b1, 1'b0, 1'b0, 1'b1, a, d);
        last_addr = a;
        last_data = d;
    endtask

    task automatic exp_clear(input string tag, input logic [ADDR_W-1:0] a);
        push(tag, 1'b1, 1'b1, 1'b0, 1'b0, a, 4'h0);
        last_addr = a;
        last_data = 4'h0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input string tag);
        resetn      = 1'b0;
        play_req    = 1'b0;
        wall_req    = 1'b0;
        clear_start = 1'b0;
        sb.delete();
        last_addr   = '0;
        last_data   = '0;
        repeat (2) @(posedge clock);
        #2;
        check_eq(tag, obs_word(), 32'h0);
        resetn = 1'b1;
    endtask

    // Scoreboard monitor: compare the entry due in this cycle.
    always @(negedge clock) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check_eq(e.tag, obs_word(), e.val);
        end
    end

    initial begin
        resetn    = 1'b0;
        play_addr = '0;
        play_data = '0;
        wall_addr = '0;
        wall_data = '0;
        do_reset("reset");

        // Single player write after reset, ack lasts one cycle.
        tick(); play_req = 1'b1; play_addr = 12'h012; play_data = 4'h5; exp_play("p1_c1", 12'h012, 4'h5);
        tick(); exp_none("p1_c2");
        tick(); play_req = 1'b0; exp_none("p1_c3");
        tick(); exp_none("p1_c4");

        // Contention from reset: PLAY first, then strict alternation.
        do_reset("reset2");
        tick();
        play_req = 1'b1; play_addr = 12'h001; play_data = 4'h1;
        wall_req = 1'b1; wall_addr = 12'h002; wall_data = 4'h2;
        exp_play("cont_c1", 12'h001, 4'h1);
        tick(); exp_wall("cont_c2", 12'h002, 4'h2);
        tick(); exp_play("cont_c3", 12'h001, 4'h1);
        tick(); exp_wall("cont_c4", 12'h002, 4'h2);
        tick(); play_req = 1'b0; wall_req = 1'b0; exp_none("cont_c5");
        tick(); exp_none("cont_c6");

        // Single requester held for six cycles: acks every other cycle.
        tick(); wall_req = 1'b1; wall_addr = 12'h3A5; wall_data = 4'h7;
        exp_wall("single_c1", 12'h3A5, 4'h7);
        tick(); exp_none("single_c2");
        tick(); exp_wall("single_c3", 12'h3A5, 4'h7);
        tick(); exp_none("single_c4");
        tick(); exp_wall("single_c5", 12'h3A5, 4'h7);
        tick(); exp_none("single_c6");
        tick(); wall_req = 1'b0; exp_none("single_c7");

        // Clear sweep with a pending wall request and a repeat clear_start mid-sweep.
        tick(); clear_start = 1'b1; wall_req = 1'b1; wall_addr = 12'h0AB; wall_data = 4'h9;
        exp_clear("clr_c1", 12'h000);
        for (int k = 1; k < int'(CELLS); k++) begin
            tick();
            clear_start = (k == 5);
            exp_clear($sformatf("clr_c%0d", k + 1), ADDR_W'(k));
        end
        tick(); clear_start = 1'b0; exp_wall("clr_c17", 12'h0AB, 4'h9);
        tick(); wall_req = 1'b0; exp_none("clr_c18");
        tick(); exp_none("clr_c19");

        // Reset in the middle of a sweep.
        tick(); clear_start = 1'b1; exp_clear("mid_c1", 12'h000);
        for (int k = 1; k < 8; k++) begin
            tick();
            clear_start = 1'b0;
            exp_clear($sformatf("mid_c%0d", k + 1), ADDR_W'(k));
        end
        tick();
        @(negedge clock);
        #1;
        resetn = 1'b0;
        sb.delete();
        last_addr = '0;
        last_data = '0;
        #1;
        check_eq("rst_async", obs_word(), 32'h0);
        @(posedge clock);
        #2;
        check_eq("rst_hold", obs_word(), 32'h0);
        resetn = 1'b1;

        // Normal grant after reset, then a fresh sweep from address 0.
        tick(); play_req = 1'b1; play_addr = 12'h0C3; play_data = 4'h6; exp_play("post_c1", 12'h0C3, 4'h6);
        tick(); play_req = 1'b0; exp_none("post_c2");
        tick(); clear_start = 1'b1; exp_clear("post_clr0", 12'h000);
        for (int k = 1; k < int'(CELLS); k++) begin
            tick();
            clear_start = 1'b0;
            exp_clear($sformatf("post_clr%0d", k), ADDR_W'(k));
        end
        tick(); exp_none("post_end1");
        tick(); exp_none("post_end2");

        // Every queued expectation must have been consumed.
        for (int i = 0; i < 8 && sb.size() > 0; i++) @(posedge clock);
        @(negedge clock);
        check_eq("drain", 32'(sb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
